// File: rtl/async_crossing_source.sv
// Write side of a gray-coded async FIFO: stores payloads, publishes a gray write index, syncs the sink read index.
// Latency: written data and the advanced widx_gray are both visible one clock after a transfer.
// Backpressure: enq_ready drops when full, when the sink is not alive, or before the source comes out of reset.
module async_crossing_source #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 1,
    parameter int SYNC  = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [WIDTH-1:0]           enq_bits,
    output logic [DEPTH*WIDTH-1:0]     mem,
    output logic [$clog2(DEPTH):0]     widx_gray,
    input  logic [$clog2(DEPTH):0]     ridx_gray,
    input  logic                       sink_valid,
    output logic                       source_valid
);
    localparam int AW = $clog2(DEPTH) + 1;
    // Full when the write index is exactly one lap ahead of the read index (top two gray bits inverted).
    localparam logic [AW-1:0] FULL_MASK = AW'(DEPTH | (DEPTH >> 1));
    localparam logic [AW-1:0] IDX_MASK  = AW'(DEPTH - 1);

    logic [AW-1:0]           widx_bin_q, widx_bin_d;
    logic [AW-1:0]           widx_gray_q, widx_gray_d;
    logic [DEPTH*WIDTH-1:0]  mem_q, mem_d;
    logic [SYNC-1:0][AW-1:0] rsync_q, rsync_d;
    logic [SYNC-1:0]         vsync_q, vsync_d;
    logic                    source_valid_q, source_valid_d;

    logic [AW-1:0] rsync;
    logic          vsync;
    logic          full;
    logic          fire;
    logic [AW-1:0] next_bin;
    logic [AW-1:0] wr_idx;

    // Shift the asynchronous read index and sink-alive flag through the synchronizer chains.
    always_comb begin
        rsync_d = {rsync_q[SYNC-2:0], ridx_gray};
        vsync_d = {vsync_q[SYNC-2:0], sink_valid};
        rsync   = rsync_q[SYNC-1];
        vsync   = vsync_q[SYNC-1];
    end

    // Flow control, write index advance and payload store; all decisions use registered state only.
    always_comb begin
        full           = (widx_gray_q == (rsync ^ FULL_MASK));
        enq_ready      = vsync & ~full & source_valid_q;
        fire           = enq_valid & enq_ready;
        next_bin       = widx_bin_q + AW'(1);
        wr_idx         = widx_bin_q & IDX_MASK;
        widx_bin_d     = widx_bin_q;
        widx_gray_d    = widx_gray_q;
        mem_d          = mem_q;
        source_valid_d = 1'b1;
        if (!vsync) begin
            // Sink is gone: restart indexing from zero; stale entries are simply abandoned.
            widx_bin_d  = '0;
            widx_gray_d = '0;
        end else if (fire) begin
            widx_bin_d  = next_bin;
            widx_gray_d = next_bin ^ (next_bin >> 1);
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == AW'(i)) begin
                    mem_d[i*WIDTH +: WIDTH] = enq_bits;
                end
            end
        end
    end

    // State registers, all cleared asynchronously by the source reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            widx_bin_q     <= '0;
            widx_gray_q    <= '0;
            mem_q          <= '0;
            rsync_q        <= '0;
            vsync_q        <= '0;
            source_valid_q <= 1'b0;
        end else begin
            widx_bin_q     <= widx_bin_d;
            widx_gray_q    <= widx_gray_d;
            mem_q          <= mem_d;
            rsync_q        <= rsync_d;
            vsync_q        <= vsync_d;
            source_valid_q <= source_valid_d;
        end
    end

    assign mem          = mem_q;
    assign widx_gray    = widx_gray_q;
    assign source_valid = source_valid_q;
endmodule
